mshr_repair_controller: RTL and testbench
=========================================

Name: mshr_repair_controller

Overview:
- Services repair requests raised by miss_status_history_register, one at a time.
- For each request it fetches the full line from next-level memory with a single request and LINE_WORDS response beats, then writes the line into the data cache.
- For a store, the store word is merged into the line and the fill is marked dirty.
- For a load, the requested word is returned to the CDB with its ROB index.
- Pulses repair_complete back to the MSHR so the entry can be freed.

Parameters:
- LINE_WORDS, 4: 32-bit words per cache line (power of 2, at least 2).
- ROB_IDX_W, $clog2(ROB_ENTRIES): ROB index width, from CORE_PKG.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, reset is asynchronous and active-high
- flush_i  in  1  pipeline flush
- repair_req_i  in  1  MSHR repair request
- repair_req_addr_i  in  32  missed byte address
- repair_req_data_i  in  32  store data
- repair_req_rob_idx_i  in  ROB_IDX_W  load ROB index
- repair_is_store_i  in  1  request is a store
- repair_ack_o  out  1  request accepted this cycle
- repair_complete_o  out  1  one-cycle pulse: repair finished
- mem_req_valid_o  out  1  line-read request
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  32  line-aligned address
- mem_resp_valid_i  in  1  response beat valid
- mem_resp_data_i  in  32  response beat word (word 0 first)
- fill_en_o  out  1  one-cycle cache line write
- fill_addr_o  out  32  line-aligned address
- fill_data_o  out  32*LINE_WORDS  line; word i at bits [32i+31:32i]
- fill_dirty_o  out  1  line holds merged store data
- cdb_valid_o  out  1  load result valid
- cdb_ready_i  in  1  CDB accepts result
- cdb_data_o  out  32  load word
- cdb_rob_idx_o  out  ROB_IDX_W  load ROB index
- busy_o  out  1  state is not IDLE

Behaviour:
- Reset: async to IDLE. All outputs 0. Internal registers cleared.
- Geometry constants:
  - OFF_W = $clog2(LINE_WORDS) + 2.
  - Word select = addr[OFF_W-1:2].
  - Line address = addr with bits [OFF_W-1:0] zeroed.
- IDLE:
  - repair_ack_o = repair_req_i, combinational; only in IDLE, 0 in every other state.
  - On ack, latch addr, data, rob_idx and is_store. Clear kill and beat_cnt. Go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid_o = 1; mem_req_addr_o holds the line address until accepted.
  - Advance to MEM_RESP on mem_req_valid_o && mem_req_ready_i.
- MEM_RESP:
  - Each mem_resp_valid_i writes mem_resp_data_i into line buffer word beat_cnt, then increments beat_cnt.
  - On the beat where beat_cnt == LINE_WORDS-1, go to FILL.
  - Response beats seen in any other state are ignored.
- FILL (exactly one cycle):
  - fill_en_o = 1; fill_addr_o = line address; fill_data_o = line buffer.
  - Store: the selected word is replaced by the latched store data; fill_dirty_o = 1.
  - Load: fill_dirty_o = 0. Next state is CDB, or DONE if kill is set.
  - Store: next state is DONE.
- CDB:
  - cdb_valid_o = 1, with cdb_data_o = selected word and cdb_rob_idx_o = latched index.
  - Held until cdb_ready_i, then go to DONE.
  - If flush_i is asserted in CDB: drop cdb_valid_o the next cycle and go to DONE without sending.
- DONE:
  - repair_complete_o = 1 for exactly one cycle, then IDLE.
  - A new request can be acked in the cycle after DONE.
- Flush handling:
  - flush_i while a load repair is active (MEM_REQ, MEM_RESP, FILL), or in the ack cycle of a load, sets sticky kill.
  - The memory transaction and the fill still complete, so the cache stays coherent; only the CDB response is suppressed.
  - Flush has no effect on store repairs.
- Simultaneous events:
  - mem_req_ready_i and mem_resp_valid_i in the same MEM_REQ cycle: the response is ignored. The memory protocol never responds before acceptance.
  - cdb_ready_i and flush_i in the same CDB cycle: the result is sent (the transfer happens) and flush is ignored.
- Reset mid-operation: return to IDLE immediately. Late memory beats are ignored in IDLE.
- busy_o = (state != IDLE).

Decomposition:
- CORE_PKG additions:
  - Parameter MSHR_LINE_WORDS.
  - Typedef enum repair_state_t {IDLE, MEM_REQ, MEM_RESP, FILL, CDB, DONE}.
  - Packed struct repair_req_t {addr, data, rob_idx, is_store}.
- One sub-module, line_fill_buffer: beat counter, word capture, store-word merge and word select, as a pure datapath with load/clear controls.
- The FSM stays in mshr_repair_controller.

Test Plan:
- Load at 0x0000_1008, rob_idx 5, LINE_WORDS=4; memory returns beats A0..A3 after a 3-cycle ready stall.
  - Required: mem_req_addr_o = 0x0000_1000.
  - Required: fill_data_o = {A3,A2,A1,A0}, fill_dirty_o = 0.
  - Required: cdb_data_o = A2, cdb_rob_idx_o = 5.
  - Required: one repair_complete_o pulse.
- Store 0xDEADBEEF at 0x0000_200C.
  - Required: fill word 3 = 0xDEADBEEF and words 0-2 come from memory; fill_dirty_o = 1.
  - Required: cdb_valid_o is never asserted.
- Load repair with flush_i pulsed during MEM_RESP.
  - Required: fill still occurs and cdb_valid_o stays 0.
  - Required: repair_complete_o pulses one cycle after FILL.
- Load in CDB state with cdb_ready_i held 0 for 4 cycles.
  - Required: cdb outputs stable for those cycles; complete pulses the cycle after ready.
- repair_req_i held high across back-to-back requests.
  - Required: repair_ack_o is high only in IDLE cycles, and a second ack arrives no earlier than the cycle after repair_complete_o.
- Async rst_i asserted mid-MEM_RESP (after 2 beats).
  - Required: all outputs 0 immediately; the remaining beats are ignored.
  - Required: the next request fetches a fresh line with beat_cnt starting at 0.

Source files
------------

// File: rtl/mshr_repair_controller_pkg.sv
// Shared types and constants for the MSHR repair controller slice.
package mshr_repair_controller_pkg;

  localparam int MSHR_LINE_WORDS = 4;
  localparam int ROB_ENTRIES     = 32;
  localparam int CORE_ROB_IDX_W  = $clog2(ROB_ENTRIES);

  typedef enum logic [2:0] {
    IDLE,
    MEM_REQ,
    MEM_RESP,
    FILL,
    CDB,
    DONE
  } repair_state_t;

  typedef struct packed {
    logic [31:0]               addr;
    logic [31:0]               data;
    logic [CORE_ROB_IDX_W-1:0] rob_idx;
    logic                      is_store;
  } repair_req_t;

  // Clears the in-line byte offset bits so the address points at the line start.
  function automatic logic [31:0] line_align(input logic [31:0] addr, input int off_w);
    return addr & ~((32'd1 << off_w) - 32'd1);
  endfunction

endpackage

// File: rtl/mshr_repair_controller_line_fill_buffer.sv
// Line buffer for a repair: counts response beats, captures each word,
// overlays the store word for the fill and selects the load word.
module mshr_repair_controller_line_fill_buffer
  import mshr_repair_controller_pkg::*;
#(
  parameter int LINE_WORDS = MSHR_LINE_WORDS,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [31:0]             beat_data_i,
  input  logic [IDX_W-1:0]        word_sel_i,
  input  logic                    merge_en_i,
  input  logic [31:0]             merge_data_i,
  output logic                    last_beat_o,
  output logic [32*LINE_WORDS-1:0] line_o,
  output logic [31:0]             sel_word_o
);

  logic [IDX_W-1:0]             beat_cnt_q, beat_cnt_d;
  logic [LINE_WORDS-1:0][31:0]  words_q, words_d;
  logic [LINE_WORDS-1:0][31:0]  merged;

  // Next beat counter and captured words; a clear restarts counting at word 0.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    words_d    = words_q;
    if (clear_i) begin
      beat_cnt_d = '0;
    end else if (load_i) begin
      words_d[beat_cnt_q] = beat_data_i;
      beat_cnt_d          = beat_cnt_q + IDX_W'(1);
    end
  end

  // Beat counter and word storage registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
      words_q    <= '0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      words_q    <= words_d;
    end
  end

  // Fill image with the store word overlaid, load word select and last-beat flag.
  always_comb begin
    merged = words_q;
    if (merge_en_i) begin
      merged[word_sel_i] = merge_data_i;
    end
    line_o      = merged;
    sel_word_o  = words_q[word_sel_i];
    last_beat_o = load_i && (beat_cnt_q == IDX_W'(LINE_WORDS - 1));
  end

endmodule

// File: rtl/mshr_repair_controller.sv
// Services one MSHR repair at a time: fetch the line, fill the cache
// (merging store data), return load data on the CDB, then signal completion.
module mshr_repair_controller
  import mshr_repair_controller_pkg::*;
#(
  parameter int LINE_WORDS = MSHR_LINE_WORDS,
  parameter int ROB_IDX_W  = CORE_ROB_IDX_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     repair_req_i,
  input  logic [31:0]              repair_req_addr_i,
  input  logic [31:0]              repair_req_data_i,
  input  logic [ROB_IDX_W-1:0]     repair_req_rob_idx_i,
  input  logic                     repair_is_store_i,
  output logic                     repair_ack_o,
  output logic                     repair_complete_o,
  output logic                     mem_req_valid_o,
  input  logic                     mem_req_ready_i,
  output logic [31:0]              mem_req_addr_o,
  input  logic                     mem_resp_valid_i,
  input  logic [31:0]              mem_resp_data_i,
  output logic                     fill_en_o,
  output logic [31:0]              fill_addr_o,
  output logic [32*LINE_WORDS-1:0] fill_data_o,
  output logic                     fill_dirty_o,
  output logic                     cdb_valid_o,
  input  logic                     cdb_ready_i,
  output logic [31:0]              cdb_data_o,
  output logic [ROB_IDX_W-1:0]     cdb_rob_idx_o,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int OFF_W = IDX_W + 2;

  repair_state_t state_q, state_d;
  repair_req_t   req_q, req_d;
  logic          kill_q, kill_d;

  logic                     accept;
  logic                     lfb_load;
  logic                     lfb_last;
  logic [32*LINE_WORDS-1:0] lfb_line;
  logic [31:0]              lfb_sel_word;
  logic [31:0]              line_addr;

  assign accept    = (state_q == IDLE) && repair_req_i && !rst_i;
  assign lfb_load  = (state_q == MEM_RESP) && mem_resp_valid_i;
  assign line_addr = line_align(req_q.addr, OFF_W);

  mshr_repair_controller_line_fill_buffer #(
    .LINE_WORDS(LINE_WORDS)
  ) u_line_fill_buffer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (accept),
    .load_i      (lfb_load),
    .beat_data_i (mem_resp_data_i),
    .word_sel_i  (req_q.addr[OFF_W-1:2]),
    .merge_en_i  (req_q.is_store),
    .merge_data_i(req_q.data),
    .last_beat_o (lfb_last),
    .line_o      (lfb_line),
    .sel_word_o  (lfb_sel_word)
  );

  // Next-state and output decode; a flush in FILL counts as already killed.
  always_comb begin
    state_d           = state_q;
    req_d             = req_q;
    kill_d            = kill_q;
    repair_ack_o      = 1'b0;
    repair_complete_o = 1'b0;
    mem_req_valid_o   = 1'b0;
    mem_req_addr_o    = '0;
    fill_en_o         = 1'b0;
    fill_addr_o       = '0;
    fill_data_o       = '0;
    fill_dirty_o      = 1'b0;
    cdb_valid_o       = 1'b0;
    cdb_data_o        = '0;
    cdb_rob_idx_o     = '0;
    busy_o            = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        repair_ack_o = accept;
        if (accept) begin
          req_d.addr     = repair_req_addr_i;
          req_d.data     = repair_req_data_i;
          req_d.rob_idx  = repair_req_rob_idx_i;
          req_d.is_store = repair_is_store_i;
          kill_d         = flush_i && !repair_is_store_i;
          state_d        = MEM_REQ;
        end
      end
      MEM_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = line_addr;
        if (flush_i && !req_q.is_store) kill_d = 1'b1;
        if (mem_req_ready_i) state_d = MEM_RESP;
      end
      MEM_RESP: begin
        if (flush_i && !req_q.is_store) kill_d = 1'b1;
        if (lfb_last) state_d = FILL;
      end
      FILL: begin
        fill_en_o    = 1'b1;
        fill_addr_o  = line_addr;
        fill_data_o  = lfb_line;
        fill_dirty_o = req_q.is_store;
        if (flush_i && !req_q.is_store) kill_d = 1'b1;
        if (req_q.is_store || kill_q || flush_i) state_d = DONE;
        else                                     state_d = CDB;
      end
      CDB: begin
        cdb_valid_o   = 1'b1;
        cdb_data_o    = lfb_sel_word;
        cdb_rob_idx_o = req_q.rob_idx;
        if (cdb_ready_i || flush_i) state_d = DONE;
      end
      DONE: begin
        repair_complete_o = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and kill flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      kill_q  <= kill_d;
    end
  end

endmodule

// File: tb/tb_mshr_repair_controller.sv
// Self-checking bench for mshr_repair_controller: scripted transactions with
// randomized parameters, per-cycle expected outputs from a transaction model.
module tb_mshr_repair_controller;
  import mshr_repair_controller_pkg::*;

  localparam int LW = 4;
  localparam int RW = CORE_ROB_IDX_W;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            repair_req_i;
  logic [31:0]     repair_req_addr_i;
  logic [31:0]     repair_req_data_i;
  logic [RW-1:0]   repair_req_rob_idx_i;
  logic            repair_is_store_i;
  logic            repair_ack_o;
  logic            repair_complete_o;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [31:0]     mem_req_addr_o;
  logic            mem_resp_valid_i;
  logic [31:0]     mem_resp_data_i;
  logic            fill_en_o;
  logic [31:0]     fill_addr_o;
  logic [32*LW-1:0] fill_data_o;
  logic            fill_dirty_o;
  logic            cdb_valid_o;
  logic            cdb_ready_i;
  logic [31:0]     cdb_data_o;
  logic [RW-1:0]   cdb_rob_idx_o;
  logic            busy_o;

  mshr_repair_controller #(.LINE_WORDS(LW), .ROB_IDX_W(RW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .repair_req_i(repair_req_i), .repair_req_addr_i(repair_req_addr_i),
    .repair_req_data_i(repair_req_data_i), .repair_req_rob_idx_i(repair_req_rob_idx_i),
    .repair_is_store_i(repair_is_store_i), .repair_ack_o(repair_ack_o),
    .repair_complete_o(repair_complete_o), .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_req_addr_o(mem_req_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
    .fill_en_o(fill_en_o), .fill_addr_o(fill_addr_o), .fill_data_o(fill_data_o),
    .fill_dirty_o(fill_dirty_o), .cdb_valid_o(cdb_valid_o), .cdb_ready_i(cdb_ready_i),
    .cdb_data_o(cdb_data_o), .cdb_rob_idx_o(cdb_rob_idx_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int vec_count = 0;
  int err_count = 0;
  logic check_en = 1'b0;

  logic             exp_ack, exp_complete, exp_mem_valid, exp_fill_en, exp_fill_dirty;
  logic             exp_cdb_valid, exp_busy;
  logic [31:0]      exp_mem_addr, exp_fill_addr, exp_cdb_data;
  logic [32*LW-1:0] exp_fill_data;
  logic [RW-1:0]    exp_cdb_rob;

  logic [31:0]      obs_mem_addr = '0;
  logic [32*LW-1:0] obs_fill_data = '0;
  logic             obs_fill_dirty = 1'b0;
  logic [31:0]      obs_cdb_data = '0;
  logic [RW-1:0]    obs_cdb_rob = '0;
  int               obs_fill_cnt = 0;
  int               obs_cdb_cnt = 0;
  int               obs_complete_cnt = 0;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("repair_ack", repair_ack_o, exp_ack);
    cmp("repair_complete", repair_complete_o, exp_complete);
    cmp("mem_req_valid", mem_req_valid_o, exp_mem_valid);
    cmp("mem_req_addr", mem_req_addr_o, exp_mem_addr);
    cmp("fill_en", fill_en_o, exp_fill_en);
    cmp("fill_addr", fill_addr_o, exp_fill_addr);
    cmp("fill_data", fill_data_o, exp_fill_data);
    cmp("fill_dirty", fill_dirty_o, exp_fill_dirty);
    cmp("cdb_valid", cdb_valid_o, exp_cdb_valid);
    cmp("cdb_data", cdb_data_o, exp_cdb_data);
    cmp("cdb_rob_idx", cdb_rob_idx_o, exp_cdb_rob);
    cmp("busy", busy_o, exp_busy);
  endtask

  // Single compare process: mid-cycle check of every output plus a record of what was seen.
  always @(negedge clk_i) begin
    if (check_en) begin
      checkOutput();
      if (mem_req_valid_o) obs_mem_addr = mem_req_addr_o;
      if (fill_en_o) begin
        obs_fill_data  = fill_data_o;
        obs_fill_dirty = fill_dirty_o;
        obs_fill_cnt++;
      end
      if (cdb_valid_o && cdb_ready_i) begin
        obs_cdb_data = cdb_data_o;
        obs_cdb_rob  = cdb_rob_idx_o;
        obs_cdb_cnt++;
      end
      if (repair_complete_o) obs_complete_cnt++;
    end
  end

  task automatic clear_exp();
    exp_ack = 0; exp_complete = 0; exp_mem_valid = 0; exp_mem_addr = '0;
    exp_fill_en = 0; exp_fill_addr = '0; exp_fill_data = '0; exp_fill_dirty = 0;
    exp_cdb_valid = 0; exp_cdb_data = '0; exp_cdb_rob = '0; exp_busy = 0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic junk_resp();
    mem_resp_valid_i = 1'($urandom_range(0, 1));
    mem_resp_data_i  = $urandom;
  endtask

  task automatic idle_cycle();
    clear_exp();
    repair_req_i = 0; flush_i = 0; mem_req_ready_i = 0; cdb_ready_i = 0;
    junk_resp();
    step();
  endtask

  // One complete repair. flush_ph: 0 none, 1 ack cycle, 2 MEM_REQ, 3 MEM_RESP, 4 FILL.
  // cdb_mode at the CDB decision cycle: 0 ready, 1 flush only, 2 ready and flush.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [RW-1:0] rob, input logic is_store,
                               input int stall, input int flush_ph, input int cdb_wait,
                               input int cdb_mode, input logic hold,
                               input logic [31:0] beat_base, input logic rand_beats);
    logic [31:0]      beats [LW];
    logic [31:0]      line_a;
    logic [32*LW-1:0] line_img;
    logic             killed;
    int               sel, b, cyc;
    line_a = addr - (addr % (LW * 4));
    sel    = int'((addr % (LW * 4)) / 4);
    for (int i = 0; i < LW; i++)
      beats[i] = rand_beats ? $urandom : beat_base + 32'h0101_0101 * i;
    for (int i = 0; i < LW; i++)
      line_img[32*i +: 32] = (is_store && i == sel) ? data : beats[i];
    killed = 0;

    // IDLE: request accepted combinationally
    clear_exp(); exp_ack = 1;
    repair_req_i = 1; repair_req_addr_i = addr; repair_req_data_i = data;
    repair_req_rob_idx_i = rob; repair_is_store_i = is_store;
    flush_i = (flush_ph == 1); mem_req_ready_i = 0; cdb_ready_i = 0;
    junk_resp();
    if (flush_i && !is_store) killed = 1;
    step();
    repair_req_i = hold; repair_req_addr_i = $urandom; repair_req_data_i = $urandom;
    repair_req_rob_idx_i = RW'($urandom); repair_is_store_i = 1'($urandom);

    // MEM_REQ with ready stall
    for (int k = 0; k <= stall; k++) begin
      clear_exp(); exp_busy = 1; exp_mem_valid = 1; exp_mem_addr = line_a;
      mem_req_ready_i = (k == stall);
      flush_i = (flush_ph == 2 && k == 0);
      junk_resp();
      if (flush_i && !is_store) killed = 1;
      step();
    end
    mem_req_ready_i = 0;

    // MEM_RESP with random beat gaps
    b = 0; cyc = 0;
    while (b < LW) begin
      clear_exp(); exp_busy = 1;
      flush_i = (flush_ph == 3 && cyc == 0);
      if (flush_i && !is_store) killed = 1;
      mem_resp_valid_i = (cyc > 6) || ($urandom_range(0, 2) != 0);
      mem_resp_data_i  = mem_resp_valid_i ? beats[b] : $urandom;
      if (mem_resp_valid_i) b++;
      cyc++;
      step();
    end

    // FILL
    clear_exp(); exp_busy = 1; exp_fill_en = 1; exp_fill_addr = line_a;
    exp_fill_data = line_img; exp_fill_dirty = is_store;
    flush_i = (flush_ph == 4);
    if (flush_i && !is_store) killed = 1;
    junk_resp();
    step();

    // CDB for surviving loads
    if (!is_store && !killed) begin
      for (int k = 0; k <= cdb_wait; k++) begin
        clear_exp(); exp_busy = 1; exp_cdb_valid = 1;
        exp_cdb_data = beats[sel]; exp_cdb_rob = rob;
        cdb_ready_i = (k == cdb_wait) && (cdb_mode != 1);
        flush_i     = (k == cdb_wait) && (cdb_mode != 0);
        junk_resp();
        step();
      end
    end

    // DONE
    clear_exp(); exp_busy = 1; exp_complete = 1;
    cdb_ready_i = 0; flush_i = 1'($urandom);
    junk_resp();
    step();
    flush_i = 0;
  endtask

  int c_cmp, c_cdb, c_fill;

  initial begin
    rst_i = 1; flush_i = 0; repair_req_i = 0; repair_req_addr_i = '0;
    repair_req_data_i = '0; repair_req_rob_idx_i = '0; repair_is_store_i = 0;
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = '0; cdb_ready_i = 0;
    clear_exp();
    step();
    check_en = 1;
    step();
    rst_i = 0;
    idle_cycle();

    // Directed load at 0x1008, rob 5, three-cycle ready stall
    $display("[TB] load 0x1008");
    c_cmp = obs_complete_cnt;
    applyStimulus(32'h0000_1008, 32'h0, 5'd5, 0, 3, 0, 0, 0, 0, 32'hA0A0_A0A0, 0);
    cmp("t1_mem_addr", obs_mem_addr, 32'h0000_1000);
    cmp("t1_fill_data", obs_fill_data, 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0);
    cmp("t1_fill_dirty", obs_fill_dirty, 0);
    cmp("t1_cdb_data", obs_cdb_data, 32'hA2A2_A2A2);
    cmp("t1_cdb_rob", obs_cdb_rob, 5);
    cmp("t1_complete_cnt", obs_complete_cnt - c_cmp, 1);
    idle_cycle();

    // Directed store 0xDEADBEEF at 0x200C
    $display("[TB] store 0x200C");
    c_cdb = obs_cdb_cnt;
    applyStimulus(32'h0000_200C, 32'hDEAD_BEEF, 5'd0, 1, 1, 0, 0, 0, 0, 32'hA0A0_A0A0, 0);
    cmp("t2_fill_data", obs_fill_data, 128'hDEADBEEF_A2A2A2A2_A1A1A1A1_A0A0A0A0);
    cmp("t2_fill_dirty", obs_fill_dirty, 1);
    cmp("t2_cdb_cnt", obs_cdb_cnt - c_cdb, 0);
    idle_cycle();

    // Load killed by a flush during MEM_RESP
    $display("[TB] load with flush in MEM_RESP");
    c_cdb = obs_cdb_cnt; c_fill = obs_fill_cnt; c_cmp = obs_complete_cnt;
    applyStimulus(32'h0000_3004, 32'h0, 5'd9, 0, 0, 3, 0, 0, 0, 32'h1111_0000, 0);
    cmp("t3_fill_cnt", obs_fill_cnt - c_fill, 1);
    cmp("t3_cdb_cnt", obs_cdb_cnt - c_cdb, 0);
    cmp("t3_complete_cnt", obs_complete_cnt - c_cmp, 1);
    idle_cycle();

    // Load held in CDB for four cycles
    $display("[TB] load with CDB backpressure");
    applyStimulus(32'h0000_400C, 32'h0, 5'd17, 0, 0, 0, 4, 0, 0, 32'h0, 1);
    idle_cycle();

    // Back-to-back requests with repair_req_i held high
    $display("[TB] back-to-back requests");
    applyStimulus(32'h0000_5000, 32'h0, 5'd1, 0, 0, 0, 0, 0, 1, 32'h0, 1);
    applyStimulus(32'h0000_5104, 32'h1234_5678, 5'd2, 1, 2, 0, 0, 0, 1, 32'h0, 1);
    applyStimulus(32'h0000_5208, 32'h0, 5'd3, 0, 0, 0, 1, 2, 0, 32'h0, 1);
    idle_cycle();

    // Async reset after two beats of MEM_RESP
    $display("[TB] reset mid MEM_RESP");
    clear_exp(); exp_ack = 1;
    repair_req_i = 1; repair_req_addr_i = 32'h0000_6008; repair_is_store_i = 0;
    repair_req_rob_idx_i = 5'd4; mem_resp_valid_i = 0;
    step();
    repair_req_i = 0;
    clear_exp(); exp_busy = 1; exp_mem_valid = 1; exp_mem_addr = 32'h0000_6000;
    mem_req_ready_i = 1;
    step();
    mem_req_ready_i = 0;
    for (int i = 0; i < 2; i++) begin
      clear_exp(); exp_busy = 1;
      mem_resp_valid_i = 1; mem_resp_data_i = 32'hBAD0_0000 + i;
      step();
    end
    clear_exp();
    rst_i = 1; mem_resp_valid_i = 1; mem_resp_data_i = 32'hBAD0_0002;
    #1;
    cmp("rst_busy_now", busy_o, 0);
    cmp("rst_mem_valid_now", mem_req_valid_o, 0);
    step();
    rst_i = 0; mem_resp_valid_i = 1; mem_resp_data_i = 32'hBAD0_0003;
    step();
    mem_resp_valid_i = 0;
    applyStimulus(32'h0000_7004, 32'h0, 5'd6, 0, 0, 0, 0, 0, 0, 32'hC0C0_C0C0, 0);
    cmp("t6_fill_data", obs_fill_data, 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0);
    cmp("t6_cdb_data", obs_cdb_data, 32'hC1C1_C1C1);
    idle_cycle();

    // Randomized repairs
    $display("[TB] random repairs");
    for (int t = 0; t < 60; t++) begin
      logic h;
      h = 1'($urandom_range(0, 3) == 0);
      applyStimulus($urandom, $urandom, RW'($urandom), 1'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    h, 32'h0, 1);
      if (!h) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle();
      end
    end
    idle_cycle();
    idle_cycle();

    check_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
